// File: rtl/param_seq_alu.sv
// rtl/param_seq_alu.sv - parametrised registered ALU with start/done handshake and optional iterative MUL/DIVU
//
// Optional feature macro: ALU_MULDIV_EN
//   defined   : MUL (shift-add) and DIVU (restoring) run one bit per cycle in ITER
//   undefined : no ITER state or iterative datapath; MUL/DIVU finish in one cycle with zero result
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while idle (busy=0)
//   op[2:0]    opcode, captured on accepted start
//   a, b       operands, captured on accepted start
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle completion pulse
//   result     registered result, held until the next op completes
//   remainder  DIVU remainder, 0 for other ops
//   zero       result == 0, registered with result
//   overflow   signed overflow for ADD/SUB, 0 otherwise

module param_seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef ALU_MULDIV_EN
        ,
        S_ITER = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Single-cycle datapath, evaluated directly on the live operands at accept.
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op)
            3'b000: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Shared iteration registers:
    //   MUL : opa = multiplicand (shifts left), opb = multiplier (shifts right), acc = product
    //   DIVU: opa = dividend, quotient bits shift into its LSB, opb = divisor, acc = partial remainder
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;

    // acc < divisor is invariant (or acc holds leading dividend bits when divisor is 0),
    // so the shifted remainder needs one extra bit only for the compare.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] fin_res;

    assign rem_shift = {acc_q, opa_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opb_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    assign fin_res   = is_div_q ? opa_q : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`ifdef ALU_MULDIV_EN
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (op[2:1] == 2'b11) begin
                        state_d  = S_ITER;
                        opa_d    = a;
                        opb_d    = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        is_div_d = op[0];
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        rem_d    = '0;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_ITER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                        opa_d = {opa_q[WIDTH-2:0], rem_ge};
                    end else begin
                        if (opb_q[0]) begin
                            acc_d = acc_q + opa_q;
                        end
                        opa_d = {opa_q[WIDTH-2:0], 1'b0};
                        opb_d = {1'b0, opb_q[WIDTH-1:1]};
                    end
                end else begin
                    // All bits consumed: publish the final values only.
                    state_d  = S_DONE;
                    result_d = fin_res;
                    rem_d    = is_div_q ? acc_q : '0;
                    zero_d   = (fin_res == '0);
                    ovf_d    = 1'b0;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifdef ALU_MULDIV_EN
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign remainder = rem_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule
